// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: register-file write-port scheduler for the in-order core.
// ALU and MEM writebacks share one write port through a round-robin arbiter.
// A per-register pending scoreboard stalls issue on RAW/WAW hazards until the
// producing write has reached the register file.
//
// Ports:
//   clk, rst_sync                     clock, synchronous active-high reset
//   i_iss_vld, i_iss_rd/rs1/rs2_addr  issue request from decode
//   o_iss_stall                       hazard, decode holds (combinational)
//   i_alu_vld/addr/dt, o_alu_rdy      ALU writeback handshake (rdy combinational)
//   i_mem_vld/addr/dt, o_mem_rdy      MEM writeback handshake (rdy combinational)
//   o_wr_en, o_wr_addr_3, o_wr_dt     register-file write port (registered)
//   o_pend                            scoreboard, one bit per register
//   o_err_unexp                       sticky: writeback hit a non-pending register
module rf_wb_scheduler #(
  parameter int unsigned NBW_ADDR = 5,
  parameter int unsigned NBW_DATA = 32
) (
  input  logic                       clk,
  input  logic                       rst_sync,
  input  logic                       i_iss_vld,
  input  logic [NBW_ADDR-1:0]        i_iss_rd_addr,
  input  logic [NBW_ADDR-1:0]        i_iss_rs1_addr,
  input  logic [NBW_ADDR-1:0]        i_iss_rs2_addr,
  output logic                       o_iss_stall,
  input  logic                       i_alu_vld,
  input  logic [NBW_ADDR-1:0]        i_alu_addr,
  input  logic [NBW_DATA-1:0]        i_alu_dt,
  output logic                       o_alu_rdy,
  input  logic                       i_mem_vld,
  input  logic [NBW_ADDR-1:0]        i_mem_addr,
  input  logic [NBW_DATA-1:0]        i_mem_dt,
  output logic                       o_mem_rdy,
  output logic                       o_wr_en,
  output logic [NBW_ADDR-1:0]        o_wr_addr_3,
  output logic [NBW_DATA-1:0]        o_wr_dt,
  output logic [(2**NBW_ADDR)-1:0]   o_pend,
  output logic                       o_err_unexp
);

  localparam int unsigned NREG = 2**NBW_ADDR;

  // Last-grant pointer: the source named here loses the next conflict.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  gnt_e                last_q;
  gnt_e                last_d;
  logic                gnt_alu;
  logic                gnt_mem;
  logic                gnt_any;
  logic [NBW_ADDR-1:0] sel_addr;
  logic [NBW_DATA-1:0] sel_dt;
  logic                sel_nz;

  logic                wr_en_q;
  logic                wr_en_d;
  logic [NBW_ADDR-1:0] wr_addr_q;
  logic [NBW_ADDR-1:0] wr_addr_d;
  logic [NBW_DATA-1:0] wr_dt_q;
  logic [NBW_DATA-1:0] wr_dt_d;
  logic [NREG-1:0]     pend_q;
  logic [NREG-1:0]     pend_d;
  logic                err_q;
  logic                err_d;
  logic                iss_stall_c;
  logic                iss_set_c;

  // Round-robin arbiter and pointer next-state.
  always_comb begin : arb_comb
    last_d  = last_q;
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    case ({i_alu_vld, i_mem_vld})
      2'b10:   gnt_alu = 1'b1;
      2'b01:   gnt_mem = 1'b1;
      2'b11: begin
        gnt_alu = (last_q == GNT_MEM);
        gnt_mem = (last_q == GNT_ALU);
      end
      default: ;
    endcase
    if (gnt_alu) begin
      last_d = GNT_ALU;
    end else if (gnt_mem) begin
      last_d = GNT_MEM;
    end
  end

  assign gnt_any  = gnt_alu | gnt_mem;
  assign sel_addr = gnt_alu ? i_alu_addr : i_mem_addr;
  assign sel_dt   = gnt_alu ? i_alu_dt : i_mem_dt;
  assign sel_nz   = (sel_addr != '0);

  // Write-port next-state; an x0 transfer is consumed without a write.
  always_comb begin : wr_comb
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dt_d   = wr_dt_q;
    if (gnt_any && sel_nz) begin
      wr_en_d   = 1'b1;
      wr_addr_d = sel_addr;
      wr_dt_d   = sel_dt;
    end
    err_d = err_q | (gnt_any & sel_nz & ~pend_q[sel_addr]);
  end

  // Hazard detection; pend_q[0] is held at zero so x0 never stalls.
  assign iss_stall_c = i_iss_vld & (pend_q[i_iss_rs1_addr] |
                                    pend_q[i_iss_rs2_addr] |
                                    pend_q[i_iss_rd_addr]);
  assign iss_set_c   = i_iss_vld & ~iss_stall_c & (i_iss_rd_addr != '0);

  // Scoreboard next-state; a set after the clear makes set win on collision.
  always_comb begin : pend_comb
    pend_d = pend_q;
    if (wr_en_q) begin
      pend_d[wr_addr_q] = 1'b0;
    end
    if (iss_set_c) begin
      pend_d[i_iss_rd_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers; transfers accepted during reset are dropped here.
  always_ff @(posedge clk) begin : regs
    if (rst_sync) begin
      last_q    <= GNT_MEM;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dt_q   <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_dt_q   <= wr_dt_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign o_iss_stall = iss_stall_c;
  assign o_alu_rdy   = gnt_alu;
  assign o_mem_rdy   = gnt_mem;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr_3 = wr_addr_q;
  assign o_wr_dt     = wr_dt_q;
  assign o_pend      = pend_q;
  assign o_err_unexp = err_q;

endmodule
